// File: rtl/lda_line_engine.sv
// Bresenham line engine for the LDA: snapshots the endpoints on i_start, then
// emits one pixel per accepted handshake and pulses o_done after the last one.
module lda_line_engine #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [XW+YW-1:0]  i_sp,
  input  logic [XW+YW-1:0]  i_ep,
  input  logic [CW-1:0]     i_color,
  input  logic              i_pix_ready,
  output logic              o_plot,
  output logic [XW-1:0]     o_x,
  output logic [YW-1:0]     o_y,
  output logic [CW-1:0]     o_color,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_dbg_state
);

  localparam int W  = (XW > YW) ? XW : YW;
  localparam int EW = W + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP1 = 3'd1;
  localparam logic [2:0] S_SETUP2 = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           state;
  logic [W-1:0]         x0, y0, x1, y1;
  logic [W-1:0]         cur_x, cur_y, dx;
  logic [W-1:0]         dy;
  logic signed [EW-1:0] err;
  logic                 steep, ystep_neg;
  logic [CW-1:0]        color;

  logic [W-1:0]         adx, ady;
  logic                 swap_pts;
  logic [W-1:0]         sx0, sy0, sx1, sy1, sdx;
  logic signed [EW-1:0] err_add;
  logic                 handshake;

  // Pixel handshake: o_plot is valid; a pixel transfers on a cycle where
  // o_plot and i_pix_ready are both 1. While o_plot=1 and ready=0 the pixel
  // (x, y, colour) is held and o_plot is never withdrawn.
  assign handshake = o_plot & i_pix_ready;

  always_comb begin
    adx      = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    ady      = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    swap_pts = (x0 > x1);
    sx0      = swap_pts ? x1 : x0;
    sy0      = swap_pts ? y1 : y0;
    sx1      = swap_pts ? x0 : x1;
    sy1      = swap_pts ? y0 : y1;
    sdx      = sx1 - sx0;
    err_add  = err + $signed({2'b00, dy});
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      x0        <= '0;
      y0        <= '0;
      x1        <= '0;
      y1        <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      steep     <= 1'b0;
      ystep_neg <= 1'b0;
      color     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            x0    <= W'(i_sp[XW-1:0]);
            y0    <= W'(i_sp[XW+YW-1:XW]);
            x1    <= W'(i_ep[XW-1:0]);
            y1    <= W'(i_ep[XW+YW-1:XW]);
            color <= i_color;
            state <= S_SETUP1;
          end
        end
        S_SETUP1: begin
          steep <= (ady > adx);
          if (ady > adx) begin
            x0 <= y0;
            y0 <= x0;
            x1 <= y1;
            y1 <= x1;
          end
          state <= S_SETUP2;
        end
        S_SETUP2: begin
          // |dy| is unaffected by the endpoint swap, so ady is reused directly
          x0        <= sx0;
          y0        <= sy0;
          x1        <= sx1;
          y1        <= sy1;
          dx        <= sdx;
          dy        <= ady;
          err       <= -$signed({2'b00, sdx >> 1});
          ystep_neg <= !(sy0 < sy1);
          cur_x     <= sx0;
          cur_y     <= sy0;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (handshake) begin
            if (cur_x == x1) begin
              state <= S_DONE;
            end else begin
              cur_x <= cur_x + 1'b1;
              if (!err_add[EW-1]) begin
                cur_y <= ystep_neg ? (cur_y - 1'b1) : (cur_y + 1'b1);
                err   <= err_add - $signed({2'b00, dx});
              end else begin
                err <= err_add;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_plot      = (state == S_RUN);
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);
  assign o_color     = color;
  assign o_x         = steep ? cur_y[XW-1:0] : cur_x[XW-1:0];
  assign o_y         = steep ? cur_x[YW-1:0] : cur_y[YW-1:0];
  assign o_dbg_state = state;

endmodule
